// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and constants for the register-file write arbiter
package regfile_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    localparam int         NUM_REGS = 32;
    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam logic       REQ_ALU  = 1'b0;
    localparam logic       REQ_MEM  = 1'b1;

endpackage

// File: rtl/decoder5to32.sv
// rtl/decoder5to32.sv - 5-to-32 one-hot decoder with enable
module decoder5to32 (
    input  logic        enable,
    input  logic [4:0]  select,
    output logic [31:0] out
);

    // One-hot of select when enabled, all zero otherwise
    always_comb begin
        out = '0;
        if (enable) begin
            out[select] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin writeback arbiter; optional REGFILE_ARB_STATS_EN conflict counter
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  port_busy,
    output logic                  wr_enable,
    output logic [ADDR_WIDTH-1:0] wr_select,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REGS-1:0]   wr_onehot
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]           conflict_count
`endif
);

    arb_state_e            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] wr_select_q, wr_select_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                  grant;
    logic                  any_valid;
    logic                  can_accept;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Pick the winner: a lone requester wins; a tie goes to whoever did not win last
    always_comb begin
        grant = REQ_ALU;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = REQ_MEM;
        end
        any_valid  = req0_valid | req1_valid;
        can_accept = (state_q == EMPTY) | ~port_busy;
        accept     = can_accept & any_valid & ~reset;
        req0_ready = accept & (grant == REQ_ALU) & req0_valid;
        req1_ready = accept & (grant == REQ_MEM) & req1_valid;
        win_addr   = (grant == REQ_MEM) ? req1_addr : req0_addr;
        win_data   = (grant == REQ_MEM) ? req1_data : req0_data;
    end

    // Output-stage next state: load on accept, drain on commit, r0 writes dropped
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_select_d  = wr_select_q;
        wr_data_d    = wr_data_q;
        if (accept) begin
            last_grant_d = grant;
            if (win_addr != ZERO_REG) begin
                wr_select_d = win_addr;
                wr_data_d   = win_data;
                state_d     = FULL;
            end else if (state_q == FULL) begin
                // Accept implies the pending write commits this cycle
                state_d = EMPTY;
            end
        end else if ((state_q == FULL) && !port_busy) begin
            state_d = EMPTY;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= EMPTY;
            last_grant_q <= REQ_MEM;
            wr_select_q  <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_select_q  <= wr_select_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_enable = (state_q == FULL) & ~port_busy;
    assign wr_select = wr_select_q;
    assign wr_data   = wr_data_q;

    decoder5to32 u_decoder (
        .enable (wr_enable),
        .select (wr_select_q),
        .out    (wr_onehot)
    );

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;

    // Count cycles where both requesters want the port; at most one can win
    always_comb begin
        conflict_d = conflict_q;
        if (req0_valid && req1_valid && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // Conflict counter register, cleared by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        port_busy;
    logic        wr_enable;
    logic [4:0]  wr_select;
    logic [31:0] wr_data;
    logic [31:0] wr_onehot;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] conflict_count;
`endif

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] oh;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   writes   = 0;
    int   w0;

    regfile_write_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .port_busy  (port_busy),
        .wr_enable  (wr_enable),
        .wr_select  (wr_select),
        .wr_data    (wr_data),
        .wr_onehot  (wr_onehot)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] oh);
        exp_t e;
        e.a  = a;
        e.d  = d;
        e.oh = oh;
        exp_q.push_back(e);
    endtask

    // Monitor: every committed write must match the next expected entry
    always @(negedge clock) begin
        if (!reset && wr_enable) begin
            writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_select", {59'd0, wr_select}, 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_wr_select", {59'd0, wr_select}, {59'd0, mon_e.a});
                chk("mon_wr_data",   {32'd0, wr_data},   {32'd0, mon_e.d});
                chk("mon_wr_onehot", {32'd0, wr_onehot}, {32'd0, mon_e.oh});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        port_busy = 0;
        repeat (2) tick();
        at_neg();
        chk("rst_wr_enable", {63'd0, wr_enable}, 64'd0);
        chk("rst_wr_select", {59'd0, wr_select}, 64'd0);
        chk("rst_wr_data",   {32'd0, wr_data},   64'd0);
        chk("rst_wr_onehot", {32'd0, wr_onehot}, 64'd0);
        chk("rst_ready0",    {63'd0, req0_ready}, 64'd0);
        chk("rst_ready1",    {63'd0, req1_ready}, 64'd0);
        tick();
        reset = 1'b0;

        // Single ALU write to r3
        req0_valid = 1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
        push(5'd3, 32'hDEADBEEF, 32'h00000008);
        at_neg();
        chk("t1_ready0", {63'd0, req0_ready}, 64'd1);
        chk("t1_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        req0_valid = 0;
        at_neg();
        chk("t1_wr_enable", {63'd0, wr_enable}, 64'd1);
        tick();

        // Continuous tie after reset: req0, req1, req0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1; req0_addr = 5'd1; req0_data = 32'hA1A1A1A1;
        req1_valid = 1; req1_addr = 5'd2; req1_data = 32'hB2B2B2B2;
        push(5'd1, 32'hA1A1A1A1, 32'h00000002);
        push(5'd2, 32'hB2B2B2B2, 32'h00000004);
        push(5'd1, 32'hA1A1A1A1, 32'h00000002);
        w0 = writes;
        at_neg();
        chk("t2_c0_ready0", {63'd0, req0_ready}, 64'd1);
        chk("t2_c0_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        at_neg();
        chk("t2_c1_ready0", {63'd0, req0_ready}, 64'd0);
        chk("t2_c1_ready1", {63'd0, req1_ready}, 64'd1);
        tick();
        at_neg();
        chk("t2_c2_ready0", {63'd0, req0_ready}, 64'd1);
        chk("t2_c2_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        req0_valid = 0; req1_valid = 0;
        at_neg();
        tick();
        chk("t2_write_count", 64'(writes - w0), 64'd3);

        // r0 write is accepted and discarded
        req1_valid = 1; req1_addr = 5'd0; req1_data = 32'h12345678;
        at_neg();
        chk("t3_ready1", {63'd0, req1_ready}, 64'd1);
        chk("t3_ready0", {63'd0, req0_ready}, 64'd0);
        tick();
        req1_valid = 0;
        at_neg();
        chk("t3_wr_enable", {63'd0, wr_enable}, 64'd0);
        chk("t3_wr_onehot", {32'd0, wr_onehot}, 64'd0);
        tick();

        // Pending write to r7 stalled by port_busy for three cycles
        req0_valid = 1; req0_addr = 5'd7; req0_data = 32'h0000_7777;
        push(5'd7, 32'h0000_7777, 32'h00000080);
        push(5'd9, 32'h0000_9999, 32'h00000200);
        at_neg();
        chk("t4_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_addr = 5'd9; req1_data = 32'h0000_9999;
        port_busy = 1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t4_busy_wr_enable", {63'd0, wr_enable}, 64'd0);
            chk("t4_busy_ready0", {63'd0, req0_ready}, 64'd0);
            chk("t4_busy_ready1", {63'd0, req1_ready}, 64'd0);
            tick();
        end
        port_busy = 0;
        at_neg();
        chk("t4_release_wr_enable", {63'd0, wr_enable}, 64'd1);
        chk("t4_release_ready1", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 0;
        at_neg();
        tick();
        at_neg();
        tick();

        // Reset while FULL drops the entry and restores tie priority to req0
        req0_valid = 1; req0_addr = 5'd5; req0_data = 32'h0000_5555;
        tick();
        req0_valid = 0;
        port_busy = 1;
        reset = 1;
        at_neg();
        chk("t5_busy_wr_enable", {63'd0, wr_enable}, 64'd0);
        tick();
        reset = 0;
        port_busy = 0;
        at_neg();
        chk("t5_post_wr_enable", {63'd0, wr_enable}, 64'd0);
        chk("t5_post_wr_select", {59'd0, wr_select}, 64'd0);
        chk("t5_post_wr_data",   {32'd0, wr_data},   64'd0);
        chk("t5_post_wr_onehot", {32'd0, wr_onehot}, 64'd0);
        tick();
        req0_valid = 1; req0_addr = 5'd10; req0_data = 32'hAAAA_0010;
        req1_valid = 1; req1_addr = 5'd11; req1_data = 32'hBBBB_0011;
        push(5'd10, 32'hAAAA_0010, 32'h00000400);
        at_neg();
        chk("t5_tie_ready0", {63'd0, req0_ready}, 64'd1);
        chk("t5_tie_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        req0_valid = 0; req1_valid = 0;
        at_neg();
        tick();

`ifdef REGFILE_ARB_STATS_EN
        // Ten tie cycles count ten conflicts
        reset = 1;
        tick();
        reset = 0;
        req0_valid = 1; req0_addr = 5'd1; req0_data = 32'h0000_0001;
        req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h0000_0002;
        for (int i = 0; i < 5; i++) begin
            push(5'd1, 32'h0000_0001, 32'h00000002);
            push(5'd2, 32'h0000_0002, 32'h00000004);
        end
        repeat (10) tick();
        req0_valid = 0; req1_valid = 0;
        at_neg();
        chk("stats_conflict_count", {48'd0, conflict_count}, 64'd10);
        tick();
        at_neg();
        tick();
`endif

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
